// File: rtl/cct_frame_packer.sv
// Packs sampled bytes into fixed-length frames and queues them for a valid/ready sink.
// Define CCT_FRAME_PACKER_CHECK_EN to store and present an XOR check byte per frame.
module cct_frame_packer #(
    parameter int BYTES_PER_FRAME = 4,
    parameter int FIFO_DEPTH      = 2
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         clear,
    input  logic [7:0]                   in_data,
    input  logic                         in_valid,
    output logic [8*BYTES_PER_FRAME-1:0] out_frame,
    output logic [7:0]                   out_check,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         overflow,
    output logic [7:0]                   frame_count
);

    localparam int FRAME_W = 8 * BYTES_PER_FRAME;
    localparam int IDX_W   = $clog2(BYTES_PER_FRAME);
    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W   = $clog2(FIFO_DEPTH + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_FRAME - 1);

    logic [IDX_W-1:0]   idx;
    logic [FRAME_W-1:0] asm_frame;
    logic [FRAME_W-1:0] frame_next;
    logic [FRAME_W-1:0] frame_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [OCC_W-1:0]   occ;
    logic               last_byte;
    logic               push;
    logic               pop;
    logic               accept;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Frame as it would look with the current byte dropped into its lane
    always_comb begin
        frame_next = asm_frame;
        for (int i = 0; i < BYTES_PER_FRAME; i++) begin
            if (idx == IDX_W'(i)) frame_next[8*i +: 8] = in_data;
        end
    end

    assign last_byte = (idx == LAST_IDX);
    assign push      = in_valid && last_byte;
    assign pop       = out_valid && out_ready;
    assign accept    = push && ((occ < OCC_W'(FIFO_DEPTH)) || pop);

    assign out_valid = (occ != '0);
    assign out_frame = frame_mem[rd_ptr];

`ifdef CCT_FRAME_PACKER_CHECK_EN
    logic [7:0] xor_run;
    logic [7:0] xor_next;
    logic [7:0] chk_mem [FIFO_DEPTH];

    // Running XOR restarts on the first byte of each frame
    assign xor_next  = ((idx == '0) ? 8'h00 : xor_run) ^ in_data;
    assign out_check = chk_mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            xor_run <= 8'h00;
            for (int i = 0; i < FIFO_DEPTH; i++) chk_mem[i] <= 8'h00;
        end else if (clear) begin
            xor_run <= 8'h00;
            for (int i = 0; i < FIFO_DEPTH; i++) chk_mem[i] <= 8'h00;
        end else begin
            if (in_valid) xor_run <= xor_next;
            if (accept) chk_mem[wr_ptr] <= xor_next;
        end
    end
`else
    assign out_check = 8'h00;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx         <= '0;
            asm_frame   <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            occ         <= '0;
            overflow    <= 1'b0;
            frame_count <= 8'h00;
            for (int i = 0; i < FIFO_DEPTH; i++) frame_mem[i] <= '0;
        end else if (clear) begin
            idx         <= '0;
            asm_frame   <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            occ         <= '0;
            overflow    <= 1'b0;
            frame_count <= 8'h00;
            for (int i = 0; i < FIFO_DEPTH; i++) frame_mem[i] <= '0;
        end else begin
            if (in_valid) begin
                asm_frame <= frame_next;
                idx       <= last_byte ? '0 : idx + 1'b1;
            end
            if (accept) begin
                frame_mem[wr_ptr] <= frame_next;
                wr_ptr            <= ptr_inc(wr_ptr);
                frame_count       <= frame_count + 8'd1;
            end
            // A completed frame with nowhere to go is dropped and flagged
            if (push && !accept) overflow <= 1'b1;
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            if (accept && !pop)      occ <= occ + 1'b1;
            else if (pop && !accept) occ <= occ - 1'b1;
        end
    end

endmodule
